// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 3-input gate under test: steps the inputs through 0..7,
// waits SETTLE cycles per vector, then checks the gate output against NAND3 or XOR3.
module gate_tt_sequencer #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_sel,
  input  logic       dut_o,
  output logic [2:0] dut_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_map
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_sel;
  logic [2:0] r_dut_i;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_err;
  logic [7:0] r_fail;

  logic       w_expected;
  logic       w_mismatch;
  logic [3:0] w_err_next;
  logic [7:0] w_fail_next;

  // The applied vector doubles as the vector index, so no separate counter is kept.
  always_comb begin
    w_expected  = r_sel ? (^r_dut_i) : ~(&r_dut_i);
    w_mismatch  = (dut_o != w_expected);
    w_err_next  = (w_mismatch && (r_err < 4'd8)) ? (r_err + 4'd1) : r_err;
    w_fail_next = w_mismatch ? (r_fail | (8'd1 << r_dut_i)) : r_fail;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_dut_i <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sel   <= gate_sel;
            r_dut_i <= '0;
            r_cnt   <= CNT_INIT;
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_dut_i <= '0;
            r_pass  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          // Abort takes priority; the comparison due at this edge is dropped.
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_dut_i <= '0;
            r_pass  <= 1'b0;
          end else begin
            r_err  <= w_err_next;
            r_fail <= w_fail_next;
            if (r_dut_i == 3'd7) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_dut_i <= r_dut_i + 3'd1;
              r_cnt   <= CNT_INIT;
              r_state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_i     = r_dut_i;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_map  = r_fail;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: the gate under test is an 8-entry truth table; expected
// schedule and results are derived from a reference truth table built in this file.
module tb_gate_tt_sequencer;

  localparam int unsigned S    = 4;
  localparam int unsigned HOLD = S + 1;
  localparam int unsigned LAT  = 8 * HOLD;

  logic       clk = 1'b0;
  logic       rst, start, abort, gate_sel, dut_o;
  logic [2:0] dut_i;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_map;
  logic [7:0] tt;

  int errors = 0;
  int checks = 0;

  gate_tt_sequencer #(.SETTLE(S)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .gate_sel  (gate_sel),
    .dut_o     (dut_o),
    .dut_i     (dut_i),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_map  (fail_map)
  );

  always #5 clk = ~clk;

  assign dut_o = tt[dut_i];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Ideal truth table of the selected function, from the parity / all-ones rules.
  function automatic logic [7:0] ref_tt(input logic sel);
    logic [7:0] r;
    int ones;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      ones = (k % 2) + ((k / 2) % 2) + ((k / 4) % 2);
      r[k] = sel ? (ones % 2 == 1) : (ones != 3);
    end
    return r;
  endfunction

  function automatic logic [7:0] low_mask(input int nv);
    int m;
    m = (nv >= 8) ? 255 : ((1 << nv) - 1);
    return 8'(m);
  endfunction

  // One run; abort_at = edge index (after the accepting edge) where abort is high, 0 = none.
  task automatic do_run(input logic sel, input logic [7:0] table_in, input int abort_at);
    logic [7:0] exp_fail;
    logic [7:0] part;
    int nv;
    int saw_done;
    tt = table_in;
    exp_fail = table_in ^ ref_tt(sel);
    start = 1'b1;
    gate_sel = sel;
    step();
    start = 1'b0;
    check("acc_busy", int'(busy), 1);
    check("acc_dut_i", int'(dut_i), 0);
    check("acc_err", int'(err_count), 0);
    check("acc_fail", int'(fail_map), 0);
    check("acc_pass", int'(pass), 0);
    for (int k = 1; k <= int'(LAT); k++) begin
      gate_sel = 1'($urandom);
      if (k == abort_at) abort = 1'b1;
      step();
      abort = 1'b0;
      if (k == abort_at) begin
        nv = (k - 1) / int'(HOLD);
        part = exp_fail & low_mask(nv);
        check("abort_busy", int'(busy), 0);
        check("abort_dut_i", int'(dut_i), 0);
        check("abort_pass", int'(pass), 0);
        check("abort_done", int'(done), 0);
        check("abort_err", int'(err_count), $countones(part));
        check("abort_fail", int'(fail_map), int'(part));
        saw_done = 0;
        for (int j = 0; j < int'(LAT) + 5; j++) begin
          step();
          if (done) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_hold_fail", int'(fail_map), int'(part));
        return;
      end
      nv = k / int'(HOLD);
      part = exp_fail & low_mask(nv);
      check("run_dut_i", int'(dut_i), (nv > 7) ? 7 : nv);
      check("run_done", int'(done), (k == int'(LAT)) ? 1 : 0);
      check("run_busy", int'(busy), (k == int'(LAT)) ? 0 : 1);
      check("run_err", int'(err_count), $countones(part));
      check("run_fail", int'(fail_map), int'(part));
    end
    check("end_pass", int'(pass), (exp_fail == 8'h00) ? 1 : 0);
    step();
    check("post_done", int'(done), 0);
    check("post_dut_i", int'(dut_i), 7);
    check("post_pass", int'(pass), (exp_fail == 8'h00) ? 1 : 0);
    check("post_fail", int'(fail_map), int'(exp_fail));
  endtask

  initial begin
    logic [7:0] rt;
    int saw_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; gate_sel = 1'b0; tt = '0;
    step(); step();
    rst = 1'b0;
    check("rst_dut_i", int'(dut_i), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_fail", int'(fail_map), 0);

    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort_busy", int'(busy), 0);

    do_run(1'b0, 8'h7F, 0);
    check("nand_ok_fail", int'(fail_map), 8'h00);
    do_run(1'b1, 8'h00, 0);
    check("xor_stuck0_fail", int'(fail_map), 8'h96);
    check("xor_stuck0_err", int'(err_count), 4);
    do_run(1'b1, 8'h7F, 0);
    check("xor_vs_nand_fail", int'(fail_map), 8'hE9);
    check("xor_vs_nand_err", int'(err_count), 5);
    do_run(1'b0, 8'hFF, 0);
    check("nand_stuck1_err", int'(err_count), 1);

    do_run(1'b1, 8'h00, 12);
    do_run(1'b0, 8'h80, 15);
    do_run(1'b1, 8'hFF, int'(LAT));

    for (int r = 0; r < 6; r++) begin
      rt = 8'($urandom);
      do_run(1'($urandom), rt, (r % 2 == 1) ? int'($urandom_range(1, LAT)) : 0);
    end

    // Start held high: second request ignored while busy, new run right after done.
    tt = 8'h96;
    gate_sel = 1'b1;
    start = 1'b1;
    step();
    for (int k = 1; k <= int'(LAT); k++) begin
      step();
      check("hold_dut_i", int'(dut_i), (k / int'(HOLD) > 7) ? 7 : k / int'(HOLD));
      check("hold_busy", int'(busy), (k == int'(LAT)) ? 0 : 1);
    end
    check("hold_done", int'(done), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("hold_gap_busy", int'(busy), 0);
    check("hold_gap_done", int'(done), 0);
    check("hold_gap_pass", int'(pass), 1);
    step();
    check("hold_restart_busy", int'(busy), 1);
    check("hold_restart_pass", int'(pass), 0);
    check("hold_restart_dut_i", int'(dut_i), 0);

    // Mid-run reset with partial errors already recorded.
    start = 1'b0;
    tt = 8'h00;
    for (int k = 0; k < 17; k++) step();
    check("pre_rst_err", int'(err_count), 2);
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    step();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_dut_i", int'(dut_i), 0);
    check("mid_rst_err", int'(err_count), 0);
    check("mid_rst_fail", int'(fail_map), 0);
    check("mid_rst_pass", int'(pass), 0);
    step();
    check("mid_rst2_done", int'(done), 0);
    check("mid_rst2_busy", int'(busy), 0);
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    saw_done = 0;
    for (int j = 0; j < int'(LAT) + 5; j++) begin
      step();
      if (done || busy) saw_done = 1;
    end
    check("post_rst_quiet", saw_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
